// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - saturating frame accumulator for multiplier products
module product_accumulator #(
    parameter int N     = 4,
    parameter int ACC_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               prod_valid_i,
    output logic               prod_ready_o,
    input  logic [2*N-1:0]     product_i,
    input  logic               prod_last_i,
    output logic               sum_valid_o,
    input  logic               sum_ready_i,
    output logic [ACC_W-1:0]   sum_o,
    output logic [7:0]         count_o,
    output logic               overflow_o
);

    // The accumulator must be able to hold at least one full product.
    if (ACC_W < 2*N) begin : g_width_check
        $error("product_accumulator: ACC_W must be >= 2*N");
    end

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [7:0]         count;
    logic               ovf;

    logic [ACC_W:0]     sum_ext;
    logic [ACC_W-1:0]   acc_next;
    logic [7:0]         count_next;
    logic               ovf_next;
    logic               accept;

    // Ready depends only on the state register and the abort input.
    assign prod_ready_o = (state == ACCUM) && !clear_i;
    assign sum_valid_o  = (state == HOLD);
    assign accept       = prod_valid_i && prod_ready_o;

    // Next accumulator value: one extra bit catches the carry out, and once
    // the flag is set the sum is pinned at full scale for the rest of the frame.
    always_comb begin
        sum_ext    = {1'b0, acc} + (ACC_W+1)'(product_i);
        ovf_next   = ovf | sum_ext[ACC_W];
        acc_next   = ovf_next ? ACC_MAX : sum_ext[ACC_W-1:0];
        count_next = (count == 8'd255) ? count : count + 8'd1;
    end

    // Frame state machine: accumulate until last, then hold the result for the consumer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ACCUM;
            acc        <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            sum_o      <= '0;
            count_o    <= '0;
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            state <= ACCUM;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc   <= acc_next;
                        count <= count_next;
                        ovf   <= ovf_next;
                        if (prod_last_i) begin
                            state      <= HOLD;
                            sum_o      <= acc_next;
                            count_o    <= count_next;
                            overflow_o <= ovf_next;
                        end
                    end
                end
                HOLD: begin
                    if (sum_ready_i) begin
                        state <= ACCUM;
                        acc   <= '0;
                        count <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential stage directly downstream of the array multiplier: consumes one 2N-bit product per cycle over a valid/ready handshake and sums a frame of products, delimited by a last flag, into a saturating ACC_W-bit accumulator. Each completed frame is presented as a dot-product result over a second valid/ready handshake, with a term count and a sticky overflow flag. Together with the multiplier it forms the team's multiply-accumulate datapath.

## Interface
- N, 4, multiplier operand width; the product input is 2N bits
- ACC_W, 16, accumulator and result width; must satisfy ACC_W >= 2N
- clk_i  in  1  single clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- clear_i  in  1  synchronous frame abort; discards any partial or held result
- prod_valid_i  in  1  product_i and prod_last_i are valid this cycle
- prod_ready_o  out  1  block can accept a product this cycle
- product_i  in  2N  unsigned product from the multiplier
- prod_last_i  in  1  marks the final product of a frame
- sum_valid_o  out  1  sum_o, count_o and overflow_o hold a completed frame
- sum_ready_i  in  1  consumer takes the result this cycle
- sum_o  out  ACC_W  saturated frame sum
- count_o  out  8  number of products in the frame, saturating at 255
- overflow_o  out  1  the frame sum exceeded 2^ACC_W-1 at least once

## Operation
- Two states: ACCUM and HOLD.
- On reset the block enters ACCUM with the accumulator, count and overflow cleared to 0. Reset values: prod_ready_o=1, sum_valid_o=0, sum_o=0, count_o=0, overflow_o=0.
- **ACCUM state**
  - prod_ready_o=1 and sum_valid_o=0.
  - A product is accepted on a cycle where prod_valid_i && prod_ready_o.
  - On accept, the block computes acc + zero-extended product_i at ACC_W+1 bits.
  - If bit ACC_W of that sum is set, acc saturates to 2^ACC_W-1 and the overflow flag is set.
  - Once saturated, acc stays at the maximum for the rest of the frame, and the overflow flag stays set.
  - On accept, count increments; at 255 it holds at 255.
  - An accept with prod_last_i=1 moves to HOLD. The final sum, count and overflow are registered into sum_o, count_o and overflow_o.
  - A one-product frame is legal: count_o=1.
- **HOLD state**
  - prod_ready_o=0 and sum_valid_o=1.
  - sum_o, count_o and overflow_o are stable until the handshake completes.
  - On sum_valid_o && sum_ready_i, the block returns to ACCUM with acc, count and the overflow flag cleared.
  - sum_o, count_o and overflow_o keep their last values after the handshake; they are don't-care while sum_valid_o=0.
- **clear_i** has priority over every other event in both states.
  - The next state is ACCUM with acc, count and the overflow flag cleared, and sum_valid_o=0.
  - A product offered in the same cycle is not accepted, and prod_ready_o is forced to 0 that cycle.
  - A held result is dropped, even if sum_ready_i=1 in the same cycle.
- prod_valid_i with prod_ready_o=0 has no effect. The upstream stage must hold its data.
- Asserting rst_i mid-frame or in HOLD immediately forces the reset values.

## Timing
- Accept throughput: one product per cycle while in ACCUM.
- Result latency: the last product is accepted at edge k, and sum_valid_o=1 from cycle k+1.
- If sum_ready_i=1 in cycle k+1, ACCUM resumes at edge k+1 and prod_ready_o=1 in cycle k+2. The minimum bubble between frames is therefore one cycle.
- prod_ready_o is a function of the state register and clear_i only. It does not depend on prod_valid_i.
- sum_valid_o is driven directly from the state register.
- All outputs are registered apart from the clear_i gating of prod_ready_o.

## Test plan
- **Basic frame** (N=4, ACC_W=16): stream products 6, 10, 15 back-to-back, last on 15 → sum_o=31, count_o=3, overflow_o=0, sum_valid_o rises one cycle after the last accept.
- **Saturation** (ACC_W=10): five products of 225 → sum_o=1023, overflow_o=1, count_o=5. The next frame [1] → sum_o=1, overflow_o=0.
- **Backpressure**: hold sum_ready_i=0 for 4 cycles after a frame → prod_ready_o=0 and the outputs stay stable. Raise sum_ready_i → prod_ready_o=1 on the following cycle and the next frame accumulates from 0.
- **Abort**: pulse clear_i after products 3 and 4, then send 7 with last → sum_o=7, count_o=1. A clear_i in HOLD with sum_ready_i=1 → no result is delivered and sum_valid_o=0 the next cycle.
- **Gaps and count**: 300 products of 1 with random prod_valid_i gaps, last on the final product → sum_o=300, count_o=255. Only handshaked beats are counted.
- **Reset mid-frame**: assert rst_i asynchronously (between clock edges) after two accepts → all outputs immediately take their reset values. The next frame [2, 3] → sum_o=5.
